// File: rtl/soc_pkg.sv
// Shared boot-path types and constants: frame marker, size limit, loader state encoding.
package soc_pkg;

   localparam logic [7:0]  BOOT_MAGIC     = 8'hA5;
   localparam int unsigned BOOT_MAX_WORDS = 256;

   typedef enum logic [2:0] {
      BS_IDLE   = 3'd0,
      BS_LEN_LO = 3'd1,
      BS_LEN_HI = 3'd2,
      BS_DATA   = 3'd3,
      BS_CSUM   = 3'd4,
      BS_DONE   = 3'd5,
      BS_ERR    = 3'd6
   } boot_state_t;

   function automatic logic [7:0] csum8_add(input logic [7:0] acc, input logic [7:0] b);
      return acc + b;
   endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Byte-stream input and instruction-RAM write port of the boot loader.
interface boot_loader_if #(
   parameter int unsigned ADDR_W = 10
) ();
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;

   modport master (output rx_data, rx_valid, input rx_ready, mem_we, mem_addr, mem_wdata);
   modport slave  (input rx_data, rx_valid, output rx_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words and flags the completing byte.
module byte_packer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_clr,
   input  logic        i_en,
   input  logic [7:0]  i_byte,
   output logic [31:0] o_word_c,
   output logic        o_done_c
);
   logic [1:0]  r_cnt;
   logic [23:0] r_buf;

   always_ff @(posedge clk) begin
      if (!rst_n || i_clr) begin
         r_cnt <= 2'd0;
         r_buf <= 24'd0;
      end else if (i_en) begin
         case (r_cnt)
            2'd0:    r_buf[7:0]   <= i_byte;
            2'd1:    r_buf[15:8]  <= i_byte;
            2'd2:    r_buf[23:16] <= i_byte;
            default: ;
         endcase
         r_cnt <= r_cnt + 2'd1;
      end
   end

   // Top lane comes straight from the input so the word is ready on the 4th handshake.
   assign o_word_c = {i_byte, r_buf};
   assign o_done_c = i_en && (r_cnt == 2'd3);

endmodule

// File: rtl/boot_loader.sv
// Loads a framed, checksummed byte stream into instruction RAM and releases CPU reset on success.
module boot_loader
   import soc_pkg::*;
#(
   parameter int unsigned ADDR_W  = 10,
   parameter logic [7:0]  MAGIC   = BOOT_MAGIC,
   parameter int unsigned TIMEOUT = 1000000
) (
   input  logic          clk,
   input  logic          rst_n,
   boot_loader_if.slave  bus,
   output logic          cpu_rst_n,
   output logic          done,
   output logic          err
);
   localparam int unsigned IDX_W = ADDR_W - 2;
   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

   localparam logic [2:0] S_IDLE   = BS_IDLE;
   localparam logic [2:0] S_LEN_LO = BS_LEN_LO;
   localparam logic [2:0] S_LEN_HI = BS_LEN_HI;
   localparam logic [2:0] S_DATA   = BS_DATA;
   localparam logic [2:0] S_CSUM   = BS_CSUM;
   localparam logic [2:0] S_DONE   = BS_DONE;
   localparam logic [2:0] S_ERR    = BS_ERR;

   logic [2:0]        r_state, w_state_nxt;
   logic              r_rx_ready, r_mem_we, r_cpu_rst_n, r_done, r_err;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [31:0]       r_mem_wdata;
   logic [7:0]        r_len_lo, r_sum;
   logic [IDX_W-1:0]  r_word_idx, r_last_idx;
   logic [TMO_W-1:0]  r_idle_cnt;

   logic        w_hs, w_in_frame, w_timeout, w_len_bad, w_is_magic;
   logic        w_pack_clr, w_pack_en, w_word_done;
   logic [15:0] w_len;
   logic [31:0] w_word;

   assign w_hs       = bus.rx_valid && r_rx_ready;
   assign w_is_magic = (bus.rx_data == MAGIC);
   assign w_len      = {bus.rx_data, r_len_lo};
   assign w_len_bad  = (w_len == 16'd0) || (w_len > 16'(BOOT_MAX_WORDS));
   assign w_in_frame = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                       (r_state == S_DATA)   || (r_state == S_CSUM);
   assign w_timeout  = w_in_frame && !w_hs && (r_idle_cnt == TMO_W'(TIMEOUT - 1));
   assign w_pack_clr = w_hs && (r_state == S_LEN_HI);
   assign w_pack_en  = w_hs && (r_state == S_DATA);

   byte_packer u_packer (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_clr    (w_pack_clr),
      .i_en     (w_pack_en),
      .i_byte   (bus.rx_data),
      .o_word_c (w_word),
      .o_done_c (w_word_done)
   );

   // Next-state logic; a timeout overrides any in-frame progress.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_hs && w_is_magic) w_state_nxt = S_LEN_LO;
         S_LEN_LO: if (w_hs) w_state_nxt = S_LEN_HI;
         S_LEN_HI: if (w_hs) w_state_nxt = w_len_bad ? S_ERR : S_DATA;
         S_DATA:   if (w_word_done && (r_word_idx == r_last_idx)) w_state_nxt = S_CSUM;
         S_CSUM:   if (w_hs) w_state_nxt = (bus.rx_data == r_sum) ? S_DONE : S_ERR;
         S_DONE:   w_state_nxt = S_DONE;
         S_ERR:    if (w_hs && w_is_magic) w_state_nxt = S_LEN_LO;
         default:  w_state_nxt = S_IDLE;
      endcase
      if (w_timeout) w_state_nxt = S_ERR;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_rx_ready  <= 1'b1;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= 32'd0;
         r_cpu_rst_n <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_len_lo    <= 8'd0;
         r_sum       <= 8'd0;
         r_word_idx  <= '0;
         r_last_idx  <= '0;
         r_idle_cnt  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_rx_ready  <= (w_state_nxt != S_DONE);
         r_done      <= (w_state_nxt == S_DONE);
         r_cpu_rst_n <= (w_state_nxt == S_DONE);
         r_err       <= (w_state_nxt == S_ERR);
         r_mem_we    <= w_word_done;
         if (w_word_done) begin
            r_mem_addr  <= {r_word_idx, 2'b00};
            r_mem_wdata <= w_word;
            r_word_idx  <= r_word_idx + IDX_W'(1);
         end
         if (w_hs && (r_state == S_LEN_LO)) r_len_lo <= bus.rx_data;
         if (w_pack_clr) begin
            r_last_idx <= IDX_W'(w_len - 16'd1);
            r_word_idx <= '0;
            r_sum      <= 8'd0;
         end
         if (w_pack_en) r_sum <= csum8_add(r_sum, bus.rx_data);
         r_idle_cnt <= (w_in_frame && !w_hs) ? r_idle_cnt + TMO_W'(1) : '0;
      end
   end

   assign bus.rx_ready  = r_rx_ready;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign cpu_rst_n     = r_cpu_rst_n;
   assign done          = r_done;
   assign err           = r_err;

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: frames built from word lists, RAM writes checked by a monitor.
module tb_boot_loader;
   localparam int unsigned TMO = 64;

   typedef struct {
      logic [9:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst_n;
   logic cpu_rst_n, done, err;
   int   total = 0;
   int   bad = 0;
   wr_t  exp_q[$];

   boot_loader_if #(.ADDR_W(10)) bus ();

   boot_loader #(.ADDR_W(10), .MAGIC(8'hA5), .TIMEOUT(TMO)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .cpu_rst_n (cpu_rst_n),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Monitor: every RAM write must match the oldest outstanding expected write.
   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got addr=%h data=%h want none", bus.mem_addr, bus.mem_wdata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("write", {bus.mem_addr, bus.mem_wdata[21:0]}, {e.addr, e.data[21:0]});
            chk("write_data", bus.mem_wdata, e.data);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      bit ok = 0;
      if (gap > 0) begin
         bus.rx_valid = 1'b0;
         repeat (gap) @(posedge clk);
         #1;
      end
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (bus.rx_ready === 1'b1) begin
            @(posedge clk);
            #1;
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL handshake: got no rx_ready want accept of %h", b);
      end
   endtask

   task automatic idle(input int n);
      bus.rx_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Frame from a word list; the expected writes follow directly from the word order.
   task automatic send_frame(input logic [31:0] w[$], input bit bad_csum, input int maxgap);
      logic [7:0] sum = 8'd0;
      logic [15:0] len;
      len = 16'(w.size());
      for (int i = 0; i < w.size(); i++) begin
         wr_t e;
         e.addr = 10'(i * 4);
         e.data = w[i];
         exp_q.push_back(e);
         for (int j = 0; j < 4; j++) sum = sum + 8'(w[i] >> (8 * j));
      end
      send_byte(8'hA5, $urandom_range(0, maxgap));
      send_byte(len[7:0], $urandom_range(0, maxgap));
      send_byte(len[15:8], $urandom_range(0, maxgap));
      for (int i = 0; i < w.size(); i++)
         for (int j = 0; j < 4; j++)
            send_byte(8'(w[i] >> (8 * j)), $urandom_range(0, maxgap));
      send_byte(bad_csum ? sum + 8'd1 : sum, $urandom_range(0, maxgap));
      bus.rx_valid = 1'b0;
   endtask

   task automatic chk_status(input string name, input bit exp_done, input bit exp_err);
      idle(3);
      chk({name, "_done"}, 32'(done), 32'(exp_done));
      chk({name, "_err"}, 32'(err), 32'(exp_err));
      chk({name, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(exp_done));
      chk({name, "_rx_ready"}, 32'(bus.rx_ready), 32'(!exp_done));
   endtask

   task automatic do_reset(input string name);
      bus.rx_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk({name, "_rst_rx_ready"}, 32'(bus.rx_ready), 32'd1);
      chk({name, "_rst_mem_we"}, 32'(bus.mem_we), 32'd0);
      chk({name, "_rst_mem_addr"}, 32'(bus.mem_addr), 32'd0);
      chk({name, "_rst_mem_wdata"}, bus.mem_wdata, 32'd0);
      chk({name, "_rst_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
      chk({name, "_rst_done"}, 32'(done), 32'd0);
      chk({name, "_rst_err"}, 32'(err), 32'd0);
      rst_n = 1'b1;
      idle(1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no end of test want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w[$];
      rst_n = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      do_reset("init");

      w = '{32'h00000013, 32'h00000093};
      send_frame(w, 1'b0, 0);
      chk_status("nominal", 1'b1, 1'b0);

      do_reset("bad_csum");
      send_frame(w, 1'b1, 0);
      chk_status("bad_csum", 1'b0, 1'b1);
      send_frame(w, 1'b0, 2);
      chk_status("recover", 1'b1, 1'b0);

      do_reset("len");
      send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
      chk_status("len_zero", 1'b0, 1'b1);
      send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h01, 0);
      chk_status("len_257", 1'b0, 1'b1);

      do_reset("tmo");
      send_byte(8'h00, 0); send_byte(8'hFF, 1); send_byte(8'h5A, 0);
      chk_status("garbage", 1'b0, 1'b0);
      send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
      send_byte(8'h11, 0); send_byte(8'h22, 0);
      idle(TMO / 2);
      chk("tmo_before", 32'(err), 32'd0);
      idle(TMO);
      chk("tmo_after", 32'(err), 32'd1);
      chk("tmo_done", 32'(done), 32'd0);

      do_reset("full");
      w = {};
      for (int i = 0; i < 256; i++) w.push_back(32'(i) * 32'h01010101);
      send_frame(w, 1'b0, 0);
      chk_status("full", 1'b1, 1'b0);

      do_reset("mid");
      begin
         wr_t e;
         e.addr = 10'h000;
         e.data = 32'h44332211;
         exp_q.push_back(e);
      end
      send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h00, 0);
      send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
      send_byte(8'h44, 0); send_byte(8'h55, 0); send_byte(8'h66, 0);
      do_reset("mid");
      w = '{32'hDEADBEEF, 32'h000000A5, 32'h12345678};
      send_frame(w, 1'b0, 5);
      chk_status("gaps", 1'b1, 1'b0);

      for (int r = 0; r < 8; r++) begin
         bit bc;
         do_reset("rand");
         w = {};
         repeat ($urandom_range(1, 8)) w.push_back($urandom);
         bc = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 1) == 1) send_byte(8'h3C, 0);
         send_frame(w, bc, 3);
         chk_status("rand", !bc, bc);
      end

      idle(5);
      chk("pending_writes", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
